ahb_slave_mem: RTL

AHB-Lite slave memory that answers master transfers from the DMA controller (the responder end of `MAddress`/`MTrans`/`MWrite`/`MWData`/`MRData`). It holds a word-addressed array that the bench or system can preload. It inserts a programmable number of wait states and returns a two-cycle ERROR response for illegal accesses. It sits on the master bus as a source or destination peripheral and is the synthesizable replacement for the behavioural bus models.

---
 rtl/ahb_slave_mem.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
//   AHB-Lite slave memory with a word-addressed array, a fixed number of
//   inserted wait states per OKAY transfer and a two-cycle ERROR response
//   for illegal accesses. Memory contents are not reset and may be preloaded
//   hierarchically through mem[].
//
// Ports
//   HCLK       in   1   clock, rising edge
//   HRESET     in   1   synchronous, active-low reset
//   HSEL       in   1   slave select
//   HADDR      in  32   byte address, HADDR[11:2] is the word index
//   HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWRITE     in   1   1 = write
//   HSIZE      in   3   only 3'b010 (word) is legal
//   HREADYIN   in   1   bus-wide HREADY
//   HWDATA     in  32   write data, sampled in the data phase
//   HRDATA     out 32   read data (registered, held outside read data phases)
//   HREADYOUT  out  1   0 = extend the current data phase
//   HRESP      out  2   00 OKAY, 01 ERROR
// ---------------------------------------------------------------------------
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADYIN,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int         AW      = $clog2(MEM_DEPTH);
  localparam logic [10:0] DEPTH_L = 11'(MEM_DEPTH);
  localparam logic [3:0] WS_M1   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  logic [31:0] mem [MEM_DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        hready_q, hready_d;
  logic [1:0]  hresp_q, hresp_d;

  logic        accept_s;
  logic        legal_s;
  logic        rd_go_s;
  logic [9:0]  rd_idx_s;
  logic [9:0]  haddr_idx_s;
  logic        unused_s;

  function automatic logic xfer_legal(input logic [9:0] idx,
                                      input logic [1:0] lsb,
                                      input logic [2:0] size);
    return ({1'b0, idx} < DEPTH_L) && (lsb == 2'b00) && (size == 3'b010);
  endfunction

  assign haddr_idx_s = HADDR[11:2];
  assign accept_s    = HSEL & HREADYIN & HTRANS[1];
  assign legal_s     = xfer_legal(haddr_idx_s, HADDR[1:0], HSIZE);
  assign unused_s    = ^{HADDR[31:12], HTRANS[0]};

  // Next-state, read-data and registered-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    hrdata_d = hrdata_q;
    rd_go_s  = 1'b0;
    rd_idx_s = idx_q;

    case (state_q)
      // Only states that drive HREADYOUT=1 may take a new address phase;
      // a stalled bus (HREADYIN low) simply leaves these states alone.
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept_s) begin
          idx_d = haddr_idx_s;
          wr_d  = HWRITE;
          if (!legal_s) begin
            state_d = S_ERR1;
          end else if (!HAS_WAIT) begin
            state_d  = S_DATA;
            rd_go_s  = !HWRITE;
            rd_idx_s = haddr_idx_s;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          rd_go_s = !wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A write committing on this same edge to the read's index wins over
    // the array, whose update is not visible until after the edge.
    if (rd_go_s) begin
      if ((state_q == S_DATA) && wr_q && (idx_q == rd_idx_s)) begin
        hrdata_d = HWDATA;
      end else begin
        hrdata_d = mem[rd_idx_s[AW-1:0]];
      end
    end else begin
      hrdata_d = hrdata_q;
    end

    if ((state_d == S_WAIT) || (state_d == S_ERR1)) begin
      hready_d = 1'b0;
    end else begin
      hready_d = 1'b1;
    end

    if ((state_d == S_ERR1) || (state_d == S_ERR2)) begin
      hresp_d = 2'b01;
    end else begin
      hresp_d = 2'b00;
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= 10'd0;
      wr_q     <= 1'b0;
      hrdata_q <= 32'd0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      hrdata_q <= hrdata_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Array write at the end of a legal write data phase; never reset
  always_ff @(posedge HCLK) begin
    if (HRESET && (state_q == S_DATA) && wr_q) begin
      mem[idx_q[AW-1:0]] <= HWDATA;
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;

endmodule
